// File: rtl/cf_uart_pkg.sv
// Shared types and constants for the CF_UART transmit-side blocks.
// The forced-release timeout is built only when CF_UART_ARB_TIMEOUT_EN is defined.
package cf_uart_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } state_t;

  localparam int DEFAULT_TIMEOUT = 1024;

endpackage

// File: rtl/cf_rr_pick.sv
// Combinational rotate-priority picker: first set bit of req scanning last+1, last+2, ... modulo N.
// Shared by the CF arbiters; carries no state of its own.
module cf_rr_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          any,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] cand;

  // Walk from the farthest slot back to last+1 so the nearest requester wins.
  always_comb begin
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = N; k >= 1; k--) begin
      cand = IW'((int'(last) + k) % N);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/cf_uart_tx_arb.sv
// Packet-atomic round-robin arbiter feeding one UART TX FIFO from NREQ byte streams.
// Optional mid-packet idle timeout is enabled with the CF_UART_ARB_TIMEOUT_EN macro.
module cf_uart_tx_arb
  import cf_uart_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int CNTW    = 16,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        fifo_wdata,
  output logic              fifo_wr,
  input  logic              fifo_full,
  output logic              busy,
  output logic [2:0]        grant_id,
  output logic [CNTW-1:0]   tx_count,
  output logic              timeout_o
);

  localparam int IW = $clog2(NREQ);

  state_t          state_reg, state_next;
  logic [IW-1:0]   grant_reg, grant_next;
  logic [IW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [CNTW-1:0] tx_count_reg;
  logic            pick_any;
  logic [IW-1:0]   pick_idx;
  logic [7:0]      lane [NREQ];
  logic            valid_g, last_g, beat, to_hit;

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("cf_uart_tx_arb: TIMEOUT must be at least 1");
  end

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_lane
    assign lane[gi] = req_data[gi*8 +: 8];
  end

  cf_rr_pick #(.N(NREQ), .IW(IW)) u_pick (
    .req  (req_valid),
    .last (rr_ptr_reg),
    .any  (pick_any),
    .idx  (pick_idx)
  );

  // Data path is a pure pass-through of the granted lane while a packet is open.
  assign busy       = (state_reg == ST_XFER);
  assign valid_g    = req_valid[grant_reg];
  assign last_g     = req_last[grant_reg];
  assign beat       = busy & valid_g & ~fifo_full;
  assign fifo_wr    = beat;
  assign fifo_wdata = busy ? lane[grant_reg] : 8'h00;
  assign grant_id   = 3'(grant_reg);
  assign tx_count   = tx_count_reg;

  always_comb begin
    req_ready = '0;
    if (busy && !fifo_full) req_ready[grant_reg] = 1'b1;
  end

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    case (state_reg)
      ST_IDLE: begin
        if (en && pick_any) begin
          state_next = ST_XFER;
          grant_next = pick_idx;
        end
      end
      ST_XFER: begin
        if ((beat && last_g) || to_hit) begin
          state_next  = ST_IDLE;
          rr_ptr_next = grant_reg;
        end
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_reg    <= ST_IDLE;
      grant_reg    <= '0;
      rr_ptr_reg   <= IW'(NREQ - 1);
      tx_count_reg <= '0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      if (beat) tx_count_reg <= tx_count_reg + CNTW'(1);
    end
  end

`ifdef CF_UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] to_cnt_reg, to_cnt_next;
  logic          timeout_reg;

  // Only cycles where the grantee has nothing to offer count; FIFO stalls do not.
  assign to_hit    = busy && !valid_g && (to_cnt_reg == TW'(TIMEOUT - 1));
  assign timeout_o = timeout_reg;

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (!busy || beat || to_hit) to_cnt_next = '0;
    else if (!valid_g)           to_cnt_next = to_cnt_reg + TW'(1);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      to_cnt_reg  <= '0;
      timeout_reg <= 1'b0;
    end else begin
      to_cnt_reg  <= to_cnt_next;
      timeout_reg <= to_hit;
    end
  end
`else
  assign to_hit    = 1'b0;
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_cf_uart_tx_arb.sv
// Scoreboard bench for cf_uart_tx_arb: lane sources obey valid/ready, a monitor checks every FIFO write.
module tb_cf_uart_tx_arb;

  localparam int NREQ = 4;
  localparam int CNTW = 16;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic              en;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        fifo_wdata;
  logic              fifo_wr;
  logic              fifo_full;
  logic              busy;
  logic [2:0]        grant_id;
  logic [CNTW-1:0]   tx_count;
  logic              timeout_o;

  cf_uart_tx_arb #(.NREQ(NREQ), .CNTW(CNTW), .TIMEOUT(16)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .en         (en),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_wdata (fifo_wdata),
    .fifo_wr    (fifo_wr),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .grant_id   (grant_id),
    .tx_count   (tx_count),
    .timeout_o  (timeout_o)
  );

  always #5 HCLK = ~HCLK;

  logic [8:0]  lane_q [NREQ][$];   // {last, data} per source
  logic [10:0] exp_q [$];          // {lane, data} in expected write order
  bit          acc [NREQ];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic load(int l, logic [7:0] d, bit last);
    lane_q[l].push_back({last, d});
  endtask

  task automatic expect_b(int l, logic [7:0] d);
    exp_q.push_back({3'(l), d});
  endtask

  task automatic wait_cnt(string name, int target, int budget);
    int n = 0;
    while (tx_count != CNTW'(target) && n < budget) begin
      @(negedge HCLK);
      n++;
    end
    chk(name, 32'(tx_count), target);
  endtask

  task automatic wait_drain(string name, int budget);
    int n = 0;
    while (exp_q.size() > 0 && n < budget) begin
      @(negedge HCLK);
      #3;
      n++;
    end
    chk(name, exp_q.size(), 0);
  endtask

  // Sources: present the queue head, pop it once the handshake has happened.
  initial begin
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    forever begin
      @(negedge HCLK);
      for (int i = 0; i < NREQ; i++) begin
        if (acc[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
        req_valid[i] = (lane_q[i].size() > 0);
        req_data[i*8 +: 8] = (lane_q[i].size() > 0) ? lane_q[i][0][7:0] : 8'h00;
        req_last[i] = (lane_q[i].size() > 0) ? lane_q[i][0][8] : 1'b0;
      end
      #1;
      for (int i = 0; i < NREQ; i++) acc[i] = req_valid[i] & req_ready[i];
    end
  end

  // Monitor: every write must match the next expected byte and its lane.
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge HCLK);
      #2;
      if (HRESETn && fifo_wr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_wr", 32'(fifo_wdata), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("wr_data", 32'(fifo_wdata), 32'(e[7:0]));
          chk("wr_lane", 32'(grant_id), 32'(e[10:8]));
        end
      end
    end
  end

  initial begin
    int base;
    HRESETn   = 1'b0;
    en        = 1'b1;
    fifo_full = 1'b0;

    // Reset values
    repeat (2) @(negedge HCLK);
    #3;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fifo_wr", 32'(fifo_wr), 0);
    chk("rst_req_ready", 32'(req_ready), 0);
    chk("rst_grant_id", 32'(grant_id), 0);
    chk("rst_tx_count", 32'(tx_count), 0);
    chk("rst_timeout", 32'(timeout_o), 0);
    chk("rst_wdata", 32'(fifo_wdata), 0);
    @(negedge HCLK);
    HRESETn = 1'b1;

    // Single requester, 3-byte packet
    load(0, 8'h11, 0); load(0, 8'h22, 0); load(0, 8'h33, 1);
    expect_b(0, 8'h11); expect_b(0, 8'h22); expect_b(0, 8'h33);
    wait_drain("single_drain", 50);
    @(negedge HCLK);
    #3;
    chk("single_busy_drop", 32'(busy), 0);
    chk("single_count", 32'(tx_count), 3);

    // Contention from reset: grant order 0,1,2,3, packets never interleave
    @(negedge HCLK);
    HRESETn = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      load(i, 8'(8'h40 + 16*i), 0);
      load(i, 8'(8'h41 + 16*i), 1);
      expect_b(i, 8'(8'h40 + 16*i));
      expect_b(i, 8'(8'h41 + 16*i));
    end
    @(negedge HCLK);
    HRESETn = 1'b1;
    wait_drain("contend_drain", 80);
    @(negedge HCLK);
    #3;
    chk("contend_count", 32'(tx_count), 8);

    // Fairness: lane1 has three packets queued, lane2 one; lane2 goes after lane1's first
    load(1, 8'hA0, 0); load(1, 8'hA1, 1);
    load(1, 8'hA2, 0); load(1, 8'hA3, 1);
    load(1, 8'hA4, 0); load(1, 8'hA5, 1);
    load(2, 8'hB0, 0); load(2, 8'hB1, 1);
    expect_b(1, 8'hA0); expect_b(1, 8'hA1);
    expect_b(2, 8'hB0); expect_b(2, 8'hB1);
    expect_b(1, 8'hA2); expect_b(1, 8'hA3);
    expect_b(1, 8'hA4); expect_b(1, 8'hA5);
    wait_drain("fair_drain", 100);

    // Backpressure: 5 full cycles in the middle of a 4-byte packet
    @(negedge HCLK);
    base = int'(tx_count);
    load(0, 8'hC0, 0); load(0, 8'hC1, 0); load(0, 8'hC2, 0); load(0, 8'hC3, 1);
    expect_b(0, 8'hC0); expect_b(0, 8'hC1); expect_b(0, 8'hC2); expect_b(0, 8'hC3);
    wait_cnt("bp_two_beats", base + 2, 40);
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #3;
      chk("bp_no_wr", 32'(fifo_wr), 0);
      chk("bp_ready_low", 32'(req_ready), 0);
      chk("bp_busy_held", 32'(busy), 1);
      @(negedge HCLK);
    end
    fifo_full = 1'b0;
    wait_drain("bp_drain", 40);
    @(negedge HCLK);
    chk("bp_count", 32'(tx_count), base + 4);

    // Disable during byte 2: packet completes, lane3 waits for en
    base = int'(tx_count);
    load(0, 8'hD0, 0); load(0, 8'hD1, 0); load(0, 8'hD2, 0); load(0, 8'hD3, 1);
    expect_b(0, 8'hD0); expect_b(0, 8'hD1); expect_b(0, 8'hD2); expect_b(0, 8'hD3);
    expect_b(3, 8'hE0);
    wait_cnt("dis_first_beat", base + 1, 40);
    en = 1'b0;
    load(3, 8'hE0, 1);
    wait_cnt("dis_packet_done", base + 4, 40);
    for (int c = 0; c < 6; c++) begin
      #3;
      chk("dis_no_grant", 32'(busy), 0);
      chk("dis_no_wr", 32'(fifo_wr), 0);
      @(negedge HCLK);
    end
    en = 1'b1;
    wait_drain("dis_drain", 40);
    chk("dis_grant_lane3", 32'(grant_id), 3);

    // Reset mid-packet: outputs drop at once, partial packet abandoned
    @(negedge HCLK);
    base = int'(tx_count);
    load(2, 8'h71, 0); load(2, 8'h72, 0); load(2, 8'h73, 0); load(2, 8'h74, 1);
    expect_b(2, 8'h71); expect_b(2, 8'h72); expect_b(2, 8'h73); expect_b(2, 8'h74);
    wait_cnt("arst_two_beats", base + 2, 40);
    #3;
    HRESETn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_fifo_wr", 32'(fifo_wr), 0);
    chk("arst_req_ready", 32'(req_ready), 0);
    chk("arst_tx_count", 32'(tx_count), 0);
    @(negedge HCLK);
    #4;
    lane_q[2].delete();
    exp_q.delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    repeat (3) @(negedge HCLK);
    #3;
    chk("arst_idle_after", 32'(busy), 0);
    chk("arst_count_after", 32'(tx_count), 0);

`ifdef CF_UART_ARB_TIMEOUT_EN
    // Grantee goes quiet mid-packet: forced release after 16 idle cycles
    begin
      int n;
      load(0, 8'h90, 0);
      expect_b(0, 8'h90);
      wait_cnt("to_first_beat", 1, 40);
      load(3, 8'h91, 1);
      expect_b(3, 8'h91);
      n = 0;
      do begin
        @(negedge HCLK);
        #3;
        n++;
      end while (!timeout_o && n < 40);
      chk("to_cycles", n, 16);
      chk("to_busy_low", 32'(busy), 0);
      wait_drain("to_drain", 20);
      chk("to_grant_lane3", 32'(grant_id), 3);
      @(negedge HCLK);
      #3;
      chk("to_pulse_one_cycle", 32'(timeout_o), 0);
    end
`else
    repeat (2) @(negedge HCLK);
    #3;
    chk("timeout_tied_low", 32'(timeout_o), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
